// File: rtl/riscv_haz_pkg.sv
// Shared types and constants for the pipeline hazard / stall control logic.
package riscv_haz_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_X0    = 5'd0;
  localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/haz_perf_counter.sv
// Saturating event counter with synchronous active-high clear and count enable.
module haz_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flushes, mul/div hold with watchdog.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipeline_stall_ctrl
  import riscv_haz_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 64,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MdOpE,
  input  logic             md_done,
  output logic             md_start,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WD_W    = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYCLES - 1);

  md_state_e       state;
  md_state_e       state_next;
  md_state_e       state_eff;
  logic [WD_W-1:0] wd_cnt;
  logic            lw_stall;
  logic            md_hold;
  logic            wd_expire;
  logic            timeout_q;

  // While reset is high the combinational outputs behave as if the FSM were IDLE.
  always_comb begin
    state_eff  = reset ? IDLE : state;
    state_next = state_eff;
    lw_stall   = ResultSrcE0 && (RdE != REG_X0) &&
                 ((Rs1D == RdE) || (Rs2D == RdE)) && !PCSrcE;
    wd_expire  = (state_eff == BUSY) && !md_done && (wd_cnt == WD_LAST);
    md_hold    = ((state_eff == IDLE) && MdOpE) ||
                 ((state_eff == BUSY) && !md_done && !wd_expire);
    md_start   = (state_eff == IDLE) && MdOpE && !reset;
    case (state_eff)
      IDLE:    if (MdOpE) state_next = BUSY;
      BUSY:    if (md_done || wd_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    StallF     = lw_stall || md_hold;
    StallD     = lw_stall || md_hold;
    StallE     = md_hold;
    FlushM     = md_hold;
    FlushD     = PCSrcE;
    FlushE     = PCSrcE || lw_stall || wd_expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == BUSY) && (state_next == BUSY)) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
      if (wd_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign md_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
  haz_perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (StallF),
    .count (stall_cnt)
  );

  haz_perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (PCSrcE),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed hazard / mul-div / watchdog scenarios
// against a cycle-level behavioural model plus hand-computed literal expectations.
module tb_pipeline_stall_ctrl;

  localparam int MD_MAX = 64;
`ifdef HAZ_PERF_CNT_EN
  localparam int      TB_CNT_W = 4;
  localparam longint  CNT_MAX  = 15;
  localparam longint  EXP_SAT  = 15;
`else
  localparam int      TB_CNT_W = 32;
  localparam longint  CNT_MAX  = 0;
  localparam longint  EXP_SAT  = 0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [4:0]          Rs1D = '0, Rs2D = '0, RdE = '0;
  logic                ResultSrcE0 = 1'b0, PCSrcE = 1'b0, MdOpE = 1'b0, md_done = 1'b0;
  logic                md_start, StallF, StallD, StallE, FlushD, FlushE, FlushM, md_timeout;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MD_MAX_CYCLES(MD_MAX), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MdOpE(MdOpE), .md_done(md_done),
    .md_start(md_start), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .md_timeout(md_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model state: whether a mul/div op is outstanding and how many BUSY cycles it has used.
  bit     m_busy = 0;
  int     m_elapsed = 0;
  bit     m_timeout = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  always @(negedge clk) begin : model
    bit busy_now, lw, expire, hold, e_start, e_flushe;
    busy_now = m_busy && !reset;
    lw       = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE)) && !PCSrcE;
    expire   = busy_now && !md_done && (m_elapsed + 1 == MD_MAX);
    hold     = (!busy_now && MdOpE) || (busy_now && !md_done && !expire);
    e_start  = !busy_now && MdOpE && !reset;
    e_flushe = PCSrcE || lw || expire;
    chk("m_md_start", md_start, e_start);
    chk("m_StallF", StallF, lw || hold);
    chk("m_StallD", StallD, lw || hold);
    chk("m_StallE", StallE, hold);
    chk("m_FlushM", FlushM, hold);
    chk("m_FlushD", FlushD, PCSrcE);
    chk("m_FlushE", FlushE, e_flushe);
    chk("m_md_timeout", md_timeout, m_timeout);
    chk("m_stall_cnt", stall_cnt, m_stall);
    chk("m_flush_cnt", flush_cnt, m_flush);
    if (reset) begin
      m_busy = 0; m_elapsed = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (busy_now) begin
        if (md_done || expire) begin
          m_busy = 0; m_elapsed = 0;
          if (expire) m_timeout = 1;
        end else begin
          m_elapsed++;
        end
      end else if (MdOpE) begin
        m_busy = 1; m_elapsed = 0;
      end
      if ((lw || hold) && m_stall < CNT_MAX) m_stall++;
      if (PCSrcE && m_flush < CNT_MAX) m_flush++;
    end
  end

  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld, input logic br,
                       input logic md, input logic dn);
    @(posedge clk);
    #1;
    reset = r; Rs1D = rs1; Rs2D = rs2; RdE = rd;
    ResultSrcE0 = ld; PCSrcE = br; MdOpE = md; md_done = dn;
    #1;
  endtask

  initial begin
    // Reset with a mul/div op visible: IDLE equations hold, start suppressed.
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_StallE", StallE, 1); chk("rst_md_start", md_start, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_StallF", StallF, 0); chk("idle_timeout", md_timeout, 0);

    // Load-use hazards.
    drive(0, 5, 1, 5, 1, 0, 0, 0);
    chk("lw_StallF", StallF, 1); chk("lw_StallD", StallD, 1);
    chk("lw_FlushE", FlushE, 1); chk("lw_StallE", StallE, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("lw_x0_StallF", StallF, 0);
    drive(0, 3, 5, 5, 1, 1, 0, 0);
    chk("lwbr_FlushD", FlushD, 1); chk("lwbr_FlushE", FlushE, 1); chk("lwbr_StallF", StallF, 0);

    // Mul/div finishing after four stall cycles.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("md_start_pulse", md_start, 1); chk("md_StallE0", StallE, 1);
    repeat (3) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk("md_busy_start", md_start, 0); chk("md_busy_FlushM", FlushM, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("md_done_StallE", StallE, 0); chk("md_done_StallF", StallF, 0);

    // Back-to-back ops.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("b2b_start1", md_start, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("b2b_done1", StallE, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("b2b_start2", md_start, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("b2b_done2", StallE, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("idle_done_StallE", StallE, 0); chk("idle_done_start", md_start, 0);

    // Done arriving exactly on the last permitted BUSY cycle.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (MD_MAX - 1) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("d64_FlushE", FlushE, 0); chk("d64_StallE", StallE, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("d64_timeout", md_timeout, 0);

    // Hung op: watchdog abort.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (MD_MAX - 1) drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("wd_pre_StallE", StallE, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("wd_FlushE", FlushE, 1); chk("wd_StallE", StallE, 0);
    chk("wd_StallF", StallF, 0); chk("wd_timeout_pre", md_timeout, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_timeout", md_timeout, 1);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_timeout_sticky", md_timeout, 1);

    // Reset in the middle of a BUSY op.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    chk("rstb_md_start", md_start, 0); chk("rstb_StallE", StallE, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rstb_timeout", md_timeout, 0); chk("rstb_StallE_after", StallE, 0);
    chk("rstb_stall_cnt", stall_cnt, 0); chk("rstb_flush_cnt", flush_cnt, 0);

    // Twenty load-use stall cycles, then a branch.
    repeat (20) drive(0, 5, 0, 5, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("cnt_stall_sat", stall_cnt, EXP_SAT);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
